// File: rtl/freq_meter_mc.sv
// Multi-channel gated frequency/duty meter: shared gate window, per-channel edge and
// high-time counters with saturation, single-shot or continuous operation.
module freq_meter_mc #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned GATE_CYCLES = 100000000,
   parameter int unsigned GATE_W      = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        sig_in,
   input  logic [NUM_CH-1:0]        ch_en,
   input  logic                     cont,
   input  logic                     start,
   output logic                     busy,
   output logic                     meas_valid,
   output logic [NUM_CH*CNT_W-1:0]  edge_cnt,
   output logic [NUM_CH*CNT_W-1:0]  high_cnt,
   output logic [NUM_CH-1:0]        ovf
);

   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

   state_t                            state;
   logic [GATE_W-1:0]                 gate_cnt;
   logic [NUM_CH-1:0]                 en_q;
   logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
   logic [NUM_CH-1:0]                 dly_q;
   logic [NUM_CH-1:0]                 lvl;
   logic [NUM_CH-1:0]                 rise;
   logic [NUM_CH-1:0][CNT_W-1:0]      edge_w, high_w, edge_nx, high_nx;
   logic [NUM_CH-1:0]                 ovf_w, ovf_nx;
   logic                              enter_gate;

   // Input synchroniser chain plus one delay stage for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         dly_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         dly_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign lvl  = sync_q[SYNC_STAGES-1];
   assign rise = lvl & ~dly_q;

   // Saturating next values of the working counters for the current gate cycle
   always_comb begin
      edge_nx = edge_w;
      high_nx = high_w;
      ovf_nx  = ovf_w;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (en_q[i]) begin
            if (rise[i] && edge_w[i] != CNT_MAX) edge_nx[i] = edge_w[i] + CNT_W'(1);
            if (lvl[i]  && high_w[i] != CNT_MAX) high_nx[i] = high_w[i] + CNT_W'(1);
         end
         ovf_nx[i] = ovf_w[i] | (edge_nx[i] == CNT_MAX) | (high_nx[i] == CNT_MAX);
      end
   end

   assign enter_gate = ((state == IDLE) && (start || cont)) || ((state == DONE) && cont);

   // Gate sequencer; results are published together with the valid pulse in DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         gate_cnt   <= '0;
         en_q       <= '0;
         edge_w     <= '0;
         high_w     <= '0;
         ovf_w      <= '0;
         busy       <= 1'b0;
         meas_valid <= 1'b0;
         edge_cnt   <= '0;
         high_cnt   <= '0;
         ovf        <= '0;
      end else begin
         meas_valid <= 1'b0;
         if (enter_gate) begin
            state    <= GATE;
            gate_cnt <= '0;
            en_q     <= ch_en;
            edge_w   <= '0;
            high_w   <= '0;
            ovf_w    <= '0;
            busy     <= 1'b1;
         end else begin
            case (state)
               IDLE: ;
               GATE: begin
                  gate_cnt <= gate_cnt + GATE_W'(1);
                  edge_w   <= edge_nx;
                  high_w   <= high_nx;
                  ovf_w    <= ovf_nx;
                  if (gate_cnt == GATE_LAST) begin
                     state      <= DONE;
                     busy       <= 1'b0;
                     meas_valid <= 1'b1;
                     edge_cnt   <= edge_nx;
                     high_cnt   <= high_nx;
                     ovf        <= ovf_nx;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_freq_meter_mc.sv
// Scoreboard bench for freq_meter_mc: periodic per-channel waveforms, expected gate
// results computed arithmetically from the waveform formula and the gate window.
module tb_freq_meter_mc;

   localparam int NUM_CH = 3;
   localparam int CNT_W  = 8;
   localparam int G      = 600;
   localparam int GW     = 10;
   localparam int S      = 2;
   localparam int MAXI   = (1 << CNT_W) - 1;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [NUM_CH-1:0]        sig_in = '0;
   logic [NUM_CH-1:0]        ch_en = '0;
   logic                     cont = 1'b0;
   logic                     start = 1'b0;
   logic                     busy, meas_valid;
   logic [NUM_CH*CNT_W-1:0]  edge_cnt, high_cnt;
   logic [NUM_CH-1:0]        ovf;

   freq_meter_mc #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_CYCLES(G), .GATE_W(GW), .SYNC_STAGES(S)
   ) dut (
      .clk(clk), .rst(rst), .sig_in(sig_in), .ch_en(ch_en), .cont(cont), .start(start),
      .busy(busy), .meas_valid(meas_valid), .edge_cnt(edge_cnt), .high_cnt(high_cnt), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                     vcyc;
      logic [NUM_CH*CNT_W-1:0] e;
      logic [NUM_CH*CNT_W-1:0] h;
      logic [NUM_CH-1:0]      o;
   } exp_t;

   exp_t exp_q[$];
   exp_t got;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   per[NUM_CH];
   int   hi[NUM_CH];
   int   ph[NUM_CH];

   always @(posedge clk) cyc <= cyc + 1;

   // Value sampled by the DUT at posedge number m for channel c
   function automatic bit wave(int c, int m);
      if (per[c] == 0 || m < 0) return 1'b0;
      return ((m + ph[c]) % per[c]) < hi[c];
   endfunction

   // Gate started at posedge a counts synchronised samples at posedges a+1 .. a+G
   function automatic exp_t model(int a, logic [NUM_CH-1:0] en);
      exp_t r;
      r.vcyc = a + G;
      r.e = '0;
      r.h = '0;
      r.o = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         int ec;
         int hc;
         ec = 0;
         hc = 0;
         if (en[c]) begin
            for (int m = a + 1; m <= a + G; m++) begin
               if (wave(c, m - S)) begin
                  hc++;
                  if (!wave(c, m - S - 1)) ec++;
               end
            end
         end
         r.e[c*CNT_W +: CNT_W] = CNT_W'(ec > MAXI ? MAXI : ec);
         r.h[c*CNT_W +: CNT_W] = CNT_W'(hc > MAXI ? MAXI : hc);
         r.o[c] = (ec >= MAXI) || (hc >= MAXI);
      end
      return r;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      for (int c = 0; c < NUM_CH; c++) sig_in[c] = wave(c, cyc + 1);
   end

   // Monitor: every valid pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (meas_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid: got pulse expected none (cycle %0d)", cyc);
         end else begin
            got = exp_q.pop_front();
            chk("valid_cycle", 64'(cyc), 64'(got.vcyc));
            chk("edge_cnt", 64'(edge_cnt), 64'(got.e));
            chk("high_cnt", 64'(high_cnt), 64'(got.h));
            chk("ovf", 64'(ovf), 64'(got.o));
            chk("busy_at_valid", 64'(busy), 64'(0));
         end
      end
   end

   task automatic set_ch(int c, int p, int h, int f);
      per[c] = p;
      hi[c]  = h;
      ph[c]  = f;
   endtask

   task automatic settle();
      repeat (5) @(negedge clk);
   endtask

   task automatic start_gate(logic [NUM_CH-1:0] en);
      @(negedge clk);
      ch_en = en;
      start = 1'b1;
      exp_q.push_back(model(cyc + 1, en));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic gate_once(logic [NUM_CH-1:0] en);
      start_gate(en);
      repeat (G + 10) @(negedge clk);
      chk("busy_after_gate", 64'(busy), 64'(0));
   endtask

   task automatic randomize_waves();
      for (int c = 0; c < NUM_CH; c++) begin
         per[c] = int'($urandom_range(2, 40));
         hi[c]  = int'($urandom_range(0, per[c]));
         ph[c]  = int'($urandom_range(0, 39));
      end
   endtask

   initial begin
      int a;
      logic [NUM_CH-1:0] en;
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_valid", 64'(meas_valid), 64'(0));
      chk("rst_edge", 64'(edge_cnt), 64'(0));
      chk("rst_high", 64'(high_cnt), 64'(0));
      chk("rst_ovf", 64'(ovf), 64'(0));
      rst = 1'b0;
      settle();

      // Directed gate; a start pulse and an enable change mid-gate must both be ignored
      set_ch(0, 10, 2, 0);
      set_ch(1, 40, 10, 3);
      set_ch(2, 7, 3, 1);
      settle();
      start_gate(3'b111);
      repeat (300) @(negedge clk);
      chk("busy_mid_gate", 64'(busy), 64'(1));
      start = 1'b1;
      ch_en = 3'b000;
      @(negedge clk);
      start = 1'b0;
      repeat (G) @(negedge clk);
      chk("busy_after_gate", 64'(busy), 64'(0));

      // Saturation, then a quiet gate that must clear the overflow flags
      set_ch(0, 2, 1, 0);
      set_ch(1, 0, 0, 0);
      set_ch(2, 3, 3, 0);
      settle();
      gate_once(3'b111);
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 0, 0, 0);
      settle();
      gate_once(3'b111);

      // Identical signals on all channels, only channel 0 enabled at gate start
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 9, 4, 0);
      settle();
      start_gate(3'b001);
      repeat (100) @(negedge clk);
      ch_en = 3'b111;
      repeat (G) @(negedge clk);

      for (int k = 0; k < 6; k++) begin
         randomize_waves();
         settle();
         gate_once(NUM_CH'($urandom));
      end

      // Continuous mode from the cont level alone; dropped during the third gate
      randomize_waves();
      en = NUM_CH'($urandom);
      settle();
      @(negedge clk);
      ch_en = en;
      cont  = 1'b1;
      a = cyc + 1;
      for (int k = 0; k < 3; k++) exp_q.push_back(model(a + k * (G + 1), en));
      while (cyc < a + 2 * (G + 1) + 100) @(negedge clk);
      cont = 1'b0;
      repeat (G + 20) @(negedge clk);
      chk("busy_after_cont", 64'(busy), 64'(0));

      // start and cont together: one gate, cont dropped inside it
      @(negedge clk);
      cont  = 1'b1;
      start = 1'b1;
      exp_q.push_back(model(cyc + 1, en));
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      cont = 1'b0;
      repeat (G + 20) @(negedge clk);
      chk("busy_after_start_cont", 64'(busy), 64'(0));

      // Reset in mid-gate abandons the gate
      start_gate(3'b111);
      repeat (150) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_edge", 64'(edge_cnt), 64'(0));
      chk("midrst_high", 64'(high_cnt), 64'(0));
      chk("midrst_ovf", 64'(ovf), 64'(0));
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (G + 20) @(negedge clk);
      chk("idle_after_rst", 64'(busy), 64'(0));
      gate_once(3'b101);

      chk("pending_expected", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/freq_meter_mc.md
Name: freq_meter_mc

Overview:
Parametrised multi-channel gated frequency/duty meter for the signal-measurement path. All channels share one gate window of GATE_CYCLES clocks. For each channel the block counts rising edges and high-level clocks inside the gate. Results are latched together and flagged with a one-cycle valid pulse for the UART/report logic.
- New relative to the single-channel meters: per-channel enable mask, single-shot or continuous mode, saturating counters with overflow flags, busy status.

Parameters:
NUM_CH, 4, number of independent input channels (1..16)
CNT_W, 32, width of each edge counter and high-time counter
GATE_CYCLES, 100000000, gate length in clk cycles (>=2); also fixes the duty denominator
GATE_W, 32, width of the gate counter; must hold GATE_CYCLES-1
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
sig_in  in  NUM_CH  asynchronous measured signals; bit i = channel i
ch_en  in  NUM_CH  channel enable mask, sampled at gate start
cont  in  1  1 = continuous back-to-back gates; 0 = single-shot
start  in  1  single-cycle pulse; starts one gate from IDLE
busy  out  1  1 while the gate is open
meas_valid  out  1  one-cycle pulse when new results are latched
edge_cnt  out  NUM_CH*CNT_W  rising edges per gate; channel i at [i*CNT_W +: CNT_W]
high_cnt  out  NUM_CH*CNT_W  clocks with synchronised input high per gate; same packing
ovf  out  NUM_CH  per-channel overflow: either counter saturated in the last gate

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all working counters 0.
  - Outputs: edge_cnt=0, high_cnt=0, ovf=0, busy=0, meas_valid=0.
  - Synchroniser flops cleared to 0.
  - Reset in mid-gate abandons the gate and issues no valid pulse.
- Synchroniser: SYNC_STAGES flops per channel, plus one delay flop.
  - edge_i = s_i & ~d_i, where s_i is the synchroniser output and d_i its delayed copy.
  - Latency from sig_in to edge_i is SYNC_STAGES+1 cycles.
- FSM states: IDLE, GATE, DONE.
  - IDLE -> GATE when start=1, or when cont=1 (level; no start needed).
  - Entering GATE: gate_cnt=0, working counters cleared, ch_en latched into en_q.
  - GATE: gate_cnt increments each cycle. On the cycle with gate_cnt==GATE_CYCLES-1, that cycle's events are still counted, then next state is DONE.
  - GATE always spans exactly GATE_CYCLES cycles; busy=1 throughout.
  - DONE (exactly one cycle):
    - Outputs updated from working counters; meas_valid=1.
    - Next state GATE if cont=1 (sampled in DONE), else IDLE.
    - The DONE cycle is dead time: its events are not counted.
- Per-channel counting in GATE, only when en_q[i]=1:
  - edge counter +1 on edge_i.
  - high counter +1 when s_i=1.
  - Both saturate at 2^CNT_W-1. Reaching saturation sets a working ovf bit; output ovf[i] is updated in DONE.
- Disabled channels report edge_cnt=0, high_cnt=0, ovf=0.
- Outputs hold their last values between DONE cycles; no partial results are visible.
- start while busy or in DONE: ignored.
- cont dropped during GATE: the current gate completes with a normal valid pulse, then IDLE.
- start and cont both 1 in IDLE: a single transition to GATE.
- Downstream use: frequency = edge_cnt*f_clk/GATE_CYCLES; duty = high_cnt/GATE_CYCLES. No divider inside the block.

Test Plan:
1. NUM_CH=2, GATE_CYCLES=1000, single-shot. ch0 = period 10 clk, 50% duty (edges well inside gate); ch1 = period 40, high 10. Pulse start. -> After 1000 GATE cycles meas_valid pulses once: ch0 edge=100, high=500; ch1 edge=25, high=250; ovf=0; busy falls with valid.
2. CNT_W=6, GATE_CYCLES=1000, ch0 = period 4. -> edge=63, high=63, ovf[0]=1. Next gate with ch0 held low -> edge=0, high=0, ovf[0]=0.
3. cont=1 held, ch0 period 10. -> meas_valid every 1001 cycles, ch0 edge=100 each time. Drop cont mid-gate -> exactly one more valid, then IDLE, busy=0.
4. ch_en=2'b01 with identical signals on both channels. -> ch1 results 0 and ovf[1]=0. Toggling ch_en mid-gate has no effect until the next gate.
5. Assert rst at gate cycle 500. -> All outputs 0 immediately; no meas_valid; after release, IDLE until start.
6. Pulse start again at gate cycle 300 (while busy). -> Ignored: exactly one valid, at the original gate end.
